// File: rtl/phase_pkg.sv
// Shared definitions for the phase error meter.
//   state_t       : measurement FSM states
//   CNT_W_DEF     : default counter / result width
//   AVG_LOG2_DEF  : default log2 of averaged window count
//   sat_max()     : all-ones value for a given width (saturation ceiling)
package phase_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        MEASURE = 1'b1
    } state_t;

    localparam int CNT_W_DEF    = 16;
    localparam int AVG_LOG2_DEF = 2;

    function automatic logic [63:0] sat_max(input int width);
        return (64'd1 << width) - 64'd1;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous load.
//   clk, reset_n : clock, async active-low reset (count clears to 0)
//   i_load       : load i_load_val this cycle (has priority over counting)
//   i_load_val   : value to load
//   i_en         : count up by one (held at the ceiling once reached)
//   o_cnt        : current count
//   o_sat        : count is at the ceiling 2^W-1
module sat_counter
    import phase_pkg::*;
#(
    parameter int W = CNT_W_DEF
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_en,
    output logic [W-1:0] o_cnt,
    output logic         o_sat
);

    localparam logic [63:0]  MAX64 = sat_max(W);
    localparam logic [W-1:0] MAX   = MAX64[W-1:0];

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_en && (r_cnt != MAX)) begin
            r_cnt <= r_cnt + W'(1);
        end
    end

    assign o_cnt = r_cnt;
    assign o_sat = (r_cnt == MAX);

endmodule

// File: rtl/phase_error_meter.sv
// Measures each reference period: cycles with pd_in high and total cycles,
// delivered over a one-entry valid/ready output register.
//   clk, reset_n  : clock, async active-low reset
//   ref_in        : reference; rising edges delimit windows
//   pd_in         : phase-difference pulse train (same register stage as ref_in)
//   out_ready     : consumer accepts the held result
//   err_valid     : result held
//   err_count     : pd_in-high cycles in the reported window(s)
//   period_count  : cycles in the reported window(s)
//   overflow      : a counter saturated in the reported window(s)
//   drop          : one-cycle pulse, a completed result was discarded
// Optional feature macro PHASE_ERR_AVG_EN: average 2^AVG_LOG2 windows per result.
//
// state   | meaning
// IDLE    | after reset, waiting for the first reference rise
// MEASURE | counting windows, each rise closes one and opens the next
module phase_error_meter
    import phase_pkg::*;
#(
    parameter int CNT_W    = CNT_W_DEF,
    parameter int AVG_LOG2 = AVG_LOG2_DEF
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             ref_in,
    input  logic             pd_in,
    input  logic             out_ready,
    output logic             err_valid,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] period_count,
    output logic             overflow,
    output logic             drop
);

    state_t           r_state, w_state_next;
    logic             r_ref_q;
    logic             w_rise;
    logic             w_measure;
    logic             w_close;
    logic [CNT_W-1:0] w_hi_cnt, w_per_cnt;
    logic             w_hi_sat, w_per_sat;
    logic             r_sat;
    logic             w_win_ovf;

    logic             w_res_fire;
    logic [CNT_W-1:0] w_res_err, w_res_per;
    logic             w_res_ovf;

    logic             r_valid, r_ovf, r_drop;
    logic [CNT_W-1:0] r_err, r_per;

    assign w_rise = ref_in & ~r_ref_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_ref_q <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_ref_q <= ref_in;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_measure    = 1'b0;
        w_close      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_rise) w_state_next = MEASURE;
            end
            MEASURE: begin
                w_measure = 1'b1;
                w_close   = w_rise;
            end
            default: w_state_next = IDLE;
        endcase
    end

    // The rise cycle itself belongs to the new window, hence load 1 / pd_in.
    sat_counter #(.W(CNT_W)) u_hi_cnt (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_load     (w_rise),
        .i_load_val (CNT_W'(pd_in)),
        .i_en       (w_measure & pd_in),
        .o_cnt      (w_hi_cnt),
        .o_sat      (w_hi_sat)
    );

    sat_counter #(.W(CNT_W)) u_per_cnt (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_load     (w_rise),
        .i_load_val (CNT_W'(1)),
        .i_en       (w_measure),
        .o_cnt      (w_per_cnt),
        .o_sat      (w_per_sat)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sat <= 1'b0;
        end else if (w_rise) begin
            r_sat <= 1'b0;
        end else if (w_measure) begin
            r_sat <= r_sat | w_hi_sat | w_per_sat;
        end
    end

    // Include the live saturation flags so a counter that hits the ceiling
    // on the last cycle of the window is still reported.
    assign w_win_ovf = r_sat | w_hi_sat | w_per_sat;

`ifdef PHASE_ERR_AVG_EN
    localparam int ACC_W = CNT_W + AVG_LOG2;

    logic [ACC_W-1:0]    r_acc_hi, r_acc_per;
    logic [ACC_W-1:0]    w_sum_hi, w_sum_per;
    logic [AVG_LOG2-1:0] r_grp;
    logic                r_acc_ovf;
    logic                w_grp_last;

    assign w_sum_hi   = r_acc_hi + ACC_W'(w_hi_cnt);
    assign w_sum_per  = r_acc_per + ACC_W'(w_per_cnt);
    assign w_grp_last = (r_grp == '1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_acc_hi  <= '0;
            r_acc_per <= '0;
            r_grp     <= '0;
            r_acc_ovf <= 1'b0;
        end else if (!w_measure) begin
            r_acc_hi  <= '0;
            r_acc_per <= '0;
            r_grp     <= '0;
            r_acc_ovf <= 1'b0;
        end else if (w_close) begin
            if (w_grp_last) begin
                r_acc_hi  <= '0;
                r_acc_per <= '0;
                r_grp     <= '0;
                r_acc_ovf <= 1'b0;
            end else begin
                r_acc_hi  <= w_sum_hi;
                r_acc_per <= w_sum_per;
                r_grp     <= r_grp + AVG_LOG2'(1);
                r_acc_ovf <= r_acc_ovf | w_win_ovf;
            end
        end
    end

    assign w_res_fire = w_close & w_grp_last;
    assign w_res_err  = w_sum_hi[ACC_W-1:AVG_LOG2];
    assign w_res_per  = w_sum_per[ACC_W-1:AVG_LOG2];
    assign w_res_ovf  = r_acc_ovf | w_win_ovf;
`else
    localparam int avg_log2_unused = AVG_LOG2;

    assign w_res_fire = w_close;
    assign w_res_err  = w_hi_cnt;
    assign w_res_per  = w_per_cnt;
    assign w_res_ovf  = w_win_ovf;
`endif

    // One-entry output register; a full register that is not being drained
    // discards the new result rather than overwriting the held one.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_valid <= 1'b0;
            r_err   <= '0;
            r_per   <= '0;
            r_ovf   <= 1'b0;
            r_drop  <= 1'b0;
        end else begin
            r_drop <= 1'b0;
            if (w_res_fire) begin
                if (!r_valid || out_ready) begin
                    r_valid <= 1'b1;
                    r_err   <= w_res_err;
                    r_per   <= w_res_per;
                    r_ovf   <= w_res_ovf;
                end else begin
                    r_drop <= 1'b1;
                end
            end else if (r_valid && out_ready) begin
                r_valid <= 1'b0;
                r_err   <= '0;
                r_per   <= '0;
                r_ovf   <= 1'b0;
            end
        end
    end

    assign err_valid    = r_valid;
    assign err_count    = r_err;
    assign period_count = r_per;
    assign overflow     = r_ovf;
    assign drop         = r_drop;

endmodule

// File: tb/tb_phase_error_meter.sv
module tb_phase_error_meter;

    typedef struct {
        int err;
        int per;
        int ovf;
    } exp_t;

    logic        clk;
    logic        reset_n;
    logic        rst_s_n;
    logic        ref_in;
    logic        pd_in;
    logic        out_ready;

    logic        err_valid;
    logic [15:0] err_count;
    logic [15:0] period_count;
    logic        overflow;
    logic        drop;

    logic        s_err_valid;
    logic [3:0]  s_err_count;
    logic [3:0]  s_period_count;
    logic        s_overflow;
    logic        s_drop;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_drop  = 0;
    int   drop_base;
    exp_t sb[$];

    phase_error_meter #(.CNT_W(16), .AVG_LOG2(2)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .ref_in       (ref_in),
        .pd_in        (pd_in),
        .out_ready    (out_ready),
        .err_valid    (err_valid),
        .err_count    (err_count),
        .period_count (period_count),
        .overflow     (overflow),
        .drop         (drop)
    );

    phase_error_meter #(.CNT_W(4), .AVG_LOG2(2)) dut_s (
        .clk          (clk),
        .reset_n      (rst_s_n),
        .ref_in       (ref_in),
        .pd_in        (pd_in),
        .out_ready    (out_ready),
        .err_valid    (s_err_valid),
        .err_count    (s_err_count),
        .period_count (s_period_count),
        .overflow     (s_overflow),
        .drop         (s_drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic push(input int e, input int p, input int o);
        exp_t x;
        x.err = e;
        x.per = p;
        x.ovf = o;
        sb.push_back(x);
    endtask

    // Drive one cycle. The handshake about to be sampled is scored before the edge.
    task automatic tick(input logic r, input logic p);
        exp_t x;
        ref_in = r;
        pd_in  = p;
        if (err_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_result", 1, 0);
            end else begin
                x = sb.pop_front();
                check("err_count", int'(err_count), x.err);
                check("period_count", int'(period_count), x.per);
                check("overflow", int'(overflow), x.ovf);
            end
        end
        @(posedge clk);
        #1;
        if (drop) n_drop++;
        if (err_count > period_count) check("err_le_period", int'(err_count), int'(period_count));
    endtask

    // One reference period: ref high for the first half, pd high for the first hi cycles.
    task automatic window(input int per, input int hi, input bit do_push);
        if (do_push) push(hi, per, 0);
        for (int i = 0; i < per; i++) tick(i < per / 2, i < hi);
    endtask

    initial begin
        reset_n   = 1'b0;
        rst_s_n   = 1'b0;
        ref_in    = 1'b0;
        pd_in     = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("rst_valid", int'(err_valid), 0);
        check("rst_err", int'(err_count), 0);
        check("rst_per", int'(period_count), 0);
        check("rst_ovf", int'(overflow), 0);
        check("rst_drop", int'(drop), 0);
        reset_n = 1'b1;

`ifdef PHASE_ERR_AVG_EN
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b1);
        push(2, 8, 0);
        window(8, 1, 0);
        window(8, 2, 0);
        window(8, 3, 0);
        window(8, 4, 0);
        window(8, 0, 0);
        check("avg_drops", n_drop, 0);
`else
        // partial window before the first rise is never reported
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b1);
        window(8, 2, 1);
        window(8, 2, 1);
        window(8, 2, 1);
        window(8, 0, 1);
        window(8, 0, 1);
        window(8, 8, 1);
        window(8, 8, 1);

        // backpressure: held result survives, second close is dropped
        drop_base = n_drop;
        out_ready = 1'b0;
        window(8, 5, 0);
        push(3, 8, 0);
        tick(1'b1, 1'b1);
        check("bp_drop_pulse", int'(drop), 1);
        check("bp_valid_held", int'(err_valid), 1);
        check("bp_err_held", int'(err_count), 8);
        tick(1'b1, 1'b1);
        check("bp_drop_one_cycle", int'(drop), 0);
        check("bp_err_stable", int'(err_count), 8);
        check("bp_per_stable", int'(period_count), 8);
        tick(1'b1, 1'b1);
        out_ready = 1'b1;
        tick(1'b1, 1'b0);
        check("bp_valid_cleared", int'(err_valid), 0);
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b0);
        check("bp_drop_count", n_drop - drop_base, 1);
        window(8, 1, 1);

        // reset mid-window with a result held
        window(8, 4, 1);
        out_ready = 1'b0;
        tick(1'b1, 1'b1);
        tick(1'b1, 1'b1);
        check("pre_rst_valid", int'(err_valid), 1);
        check("pre_rst_err", int'(err_count), 4);
        reset_n = 1'b0;
        #1;
        check("mid_rst_valid", int'(err_valid), 0);
        check("mid_rst_err", int'(err_count), 0);
        check("mid_rst_per", int'(period_count), 0);
        check("mid_rst_ovf", int'(overflow), 0);
        check("mid_rst_drop", int'(drop), 0);
        sb.delete();
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        reset_n   = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b1);
        window(8, 6, 1);
        window(8, 7, 1);
        window(8, 0, 0);
        check("drops_total", n_drop, 1);

        // saturation on the narrow instance
        reset_n = 1'b0;
        rst_s_n = 1'b1;
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        window(20, 20, 0);
        tick(1'b1, 1'b1);
        check("sat_valid", int'(s_err_valid), 1);
        check("sat_err", int'(s_err_count), 15);
        check("sat_per", int'(s_period_count), 15);
        check("sat_ovf", int'(s_overflow), 1);
        for (int i = 1; i < 8; i++) tick(i < 4, i < 3);
        tick(1'b1, 1'b0);
        check("post_sat_valid", int'(s_err_valid), 1);
        check("post_sat_err", int'(s_err_count), 3);
        check("post_sat_per", int'(s_period_count), 8);
        check("post_sat_ovf", int'(s_overflow), 0);
`endif

        check("scoreboard_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
